// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS load/store unit: access sizes, FSM states, lane widths.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_RWAIT = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/mips_lane_align.sv
// Little-endian lane steering: sub-word load extraction/extension and store merge.
module mips_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]        lane_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [WORD_W-1:0] read_word_i,
    input  logic [WORD_W-1:0] store_data_i,
    output logic [WORD_W-1:0] load_value_o,
    output logic [WORD_W-1:0] merged_word_o
);

    logic [BYTE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;
    logic [WORD_W-1:0] lane_mask;
    logic [WORD_W-1:0] lane_data;

    always_comb begin
        byte_v        = BYTE_W'(read_word_i >> {lane_i, 3'b000});
        half_v        = lane_i[1] ? read_word_i[WORD_W-1:HALF_W] : read_word_i[HALF_W-1:0];
        load_value_o  = read_word_i;
        lane_mask     = '1;
        lane_data     = store_data_i;
        case (size_i)
            SIZE_BYTE: begin
                load_value_o = {{(WORD_W-BYTE_W){signed_i & byte_v[BYTE_W-1]}}, byte_v};
                lane_mask    = 32'h0000_00FF << {lane_i, 3'b000};
                lane_data    = {4{store_data_i[BYTE_W-1:0]}};
            end
            SIZE_HALF: begin
                load_value_o = {{(WORD_W-HALF_W){signed_i & half_v[HALF_W-1]}}, half_v};
                lane_mask    = 32'h0000_FFFF << {lane_i[1], 4'b0000};
                lane_data    = {2{store_data_i[HALF_W-1:0]}};
            end
            default: begin
                load_value_o = read_word_i;
                lane_mask    = '1;
                lane_data    = store_data_i;
            end
        endcase
        // Untouched lanes come straight from the read word, bit-exact.
        merged_word_o = (read_word_i & ~lane_mask) | (lane_data & lane_mask);
    end

endmodule

// File: rtl/mips_load_store_unit.sv
// Load/store initiator for a word-addressed data memory with registered read and
// synchronous write; sub-word stores are done as read-modify-write.
module mips_load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int MemSize = 4096
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        IsStore,
    input  logic [1:0]  Size,
    input  logic        SignedLoad,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Ready,
    output logic        Done,
    output logic        Error,
    output logic [31:0] LoadData,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] MemAdress,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData
);

    localparam logic [31:0] MEM_WORDS = 32'(MemSize);

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic [31:0] ldata_q, ldata_d;
    logic [31:0] wdata_q, wdata_d;

    logic        req_err;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    mips_lane_align u_align (
        .lane_i        (addr_q[1:0]),
        .size_i        (size_q),
        .signed_i      (signed_q),
        .read_word_i   (MemReadData),
        .store_data_i  (wdata_q),
        .load_value_o  (load_value),
        .merged_word_o (merged_word)
    );

    always_comb begin
        req_err = (Size == 2'b11)
               || (Size == SIZE_HALF && Addr[0])
               || (Size == SIZE_WORD && Addr[1:0] != 2'b00)
               || ({2'b00, Addr[31:2]} >= MEM_WORDS);
    end

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        err_d    = err_q;
        ldata_d  = ldata_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    store_d  = IsStore;
                    size_d   = Size;
                    signed_d = SignedLoad;
                    addr_d   = Addr;
                    err_d    = req_err;
                    wdata_d  = StoreData;
                    if (req_err) begin
                        state_d = ST_DONE;
                    end else if (IsStore && Size == SIZE_WORD) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ:  state_d = ST_RWAIT;
            ST_RWAIT: begin
                // Store operand is overwritten by the merged word it produces.
                if (store_q) begin
                    wdata_d = merged_word;
                    state_d = ST_WRITE;
                end else begin
                    ldata_d = load_value;
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            ldata_q <= ldata_d;
        end
    end

    always_ff @(posedge Clk) begin
        store_q  <= store_d;
        size_q   <= size_d;
        signed_q <= signed_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
    end

    // Strobes are gated by Reset so an aborted access never commits on the reset edge.
    always_comb begin
        Ready        = (state_q == ST_IDLE);
        Done         = (state_q == ST_DONE);
        Error        = (state_q == ST_DONE) && err_q;
        LoadData     = ldata_q;
        MemRead      = (state_q == ST_READ) && !Reset;
        MemWrite     = (state_q == ST_WRITE) && !Reset;
        MemAdress    = '0;
        MemWriteData = '0;
        if (state_q == ST_READ || state_q == ST_RWAIT || state_q == ST_WRITE) begin
            MemAdress = {2'b00, addr_q[31:2]};
        end
        if (state_q == ST_WRITE) begin
            MemWriteData = wdata_q;
        end
    end

endmodule
